ysyx_220053_mem_arbiter: RTL

- Single-outstanding arbiter that shares one 64-bit memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Sits between both units and the pmem bridge.
- Latches a request, issues it on the memory port, and routes the response back to the owning requester.
- Supports an IFU flush, so fetches in flight at a branch redirect are dropped.

---
 rtl/ysyx_220053_arb_pkg.sv | 19 +
 rtl/ysyx_220053_arb_pick.sv | 38 +++
 rtl/ysyx_220053_mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ysyx_220053_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding, width defaults.
package ysyx_220053_arb_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_220053_arb_pick.sv
// Two-way grant logic. With YSYX_220053_ARB_RR_EN defined, ties alternate via rr_ptr;
// otherwise the LSU always wins a tie.
module ysyx_220053_arb_pick #(
    parameter int RST_PRIO_LSU = 1
) (
`ifdef YSYX_220053_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic en,
    input  logic ifu_req,
    input  logic lsu_req,
    output logic gnt_ifu,
    output logic gnt_lsu
);

    logic lsu_first;

`ifdef YSYX_220053_ARB_RR_EN
    logic rr_ptr;

    // rr_ptr==1: LSU wins the next tie; it points away from whoever was granted last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         rr_ptr <= (RST_PRIO_LSU != 0);
        else if (gnt_ifu) rr_ptr <= 1'b1;
        else if (gnt_lsu) rr_ptr <= 1'b0;
    end

    assign lsu_first = rr_ptr;
`else
    // The reset pointer only matters for round-robin; fixed priority is always LSU.
    assign lsu_first = (RST_PRIO_LSU != 0) | 1'b1;
`endif

    assign gnt_lsu = en & lsu_req & (~ifu_req | lsu_first);
    assign gnt_ifu = en & ifu_req & (~lsu_req | ~lsu_first);

endmodule

// File: rtl/ysyx_220053_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU, with IFU flush.
// Tie policy: round-robin when YSYX_220053_ARB_RR_EN is defined, else LSU fixed priority.
module ysyx_220053_mem_arbiter
    import ysyx_220053_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RST_PRIO_LSU = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic                ifu_flush,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e          state, state_nxt;
    arb_owner_e          owner;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;
    logic [DATA_W-1:0]   ifu_rdata_q, lsu_rdata_q;
    logic                flush_pend;
    logic                gnt_ifu, gnt_lsu;
    logic                idle;

    assign idle = (state == IDLE);

    // A flushed fetch is never granted; readies stay low while reset is held.
    ysyx_220053_arb_pick #(
        .RST_PRIO_LSU(RST_PRIO_LSU)
    ) u_pick (
`ifdef YSYX_220053_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .en      (idle & rst),
        .ifu_req (ifu_req_valid & ~ifu_flush),
        .lsu_req (lsu_req_valid),
        .gnt_ifu (gnt_ifu),
        .gnt_lsu (gnt_lsu)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_ifu | gnt_lsu) state_nxt = REQ;
            REQ:     if (mem_req_ready)     state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid)     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_lsu) begin
                owner   <= OWN_LSU;
                addr_q  <= lsu_addr;
                wen_q   <= lsu_wen;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else if (gnt_ifu) begin
                owner   <= OWN_IFU;
                addr_q  <= ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // A flushed fetch still runs to completion on the memory side; only its strobe is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            if (state == RESP)
                flush_pend <= 1'b0;
            else if (ifu_flush && owner == OWN_IFU && !idle)
                flush_pend <= 1'b1;
            if (state == WAIT && mem_rsp_valid) begin
                if (owner == OWN_IFU) ifu_rdata_q <= mem_rdata;
                else                  lsu_rdata_q <= mem_rdata;
            end
        end
    end

    assign ifu_req_ready = gnt_ifu;
    assign lsu_req_ready = gnt_lsu;

    assign mem_req_valid = (state == REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_rsp_valid = (state == RESP) && (owner == OWN_IFU) && !flush_pend && !ifu_flush;
    assign lsu_rsp_valid = (state == RESP) && (owner == OWN_LSU);
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rdata     = lsu_rdata_q;

endmodule
